// File: rtl/approx_accum_stream_pkg.sv
// Shared definitions for the approximate streaming accumulator.
// FSM state encodings used by the top-level controller.
package approx_accum_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/approx_lsb_adder.sv
// Lower-part-OR approximate adder: low APPROX_LSB bits are ORed, upper bits exact.
// Purely combinational; exact=1 collapses to a normal full-width add.
module approx_lsb_adder #(
  parameter int ACC_W      = 12,
  parameter int APPROX_LSB = 4
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             exact,
  output logic [ACC_W-1:0] sum,
  output logic             cout
);

  localparam logic [ACC_W-1:0] LOW_MASK = {ACC_W{1'b1}} >> (ACC_W - APPROX_LSB);

  logic [ACC_W-1:0] mask;
  logic             cin;
  logic [ACC_W:0]   hi;

  assign mask = exact ? '0 : LOW_MASK;

  // Carry into the exact part is generated from the top approximated bit pair.
  generate
    if (APPROX_LSB > 0) begin : g_cin
      assign cin = ~exact & a[APPROX_LSB-1] & b[APPROX_LSB-1];
    end else begin : g_nocin
      assign cin = 1'b0;
    end
  endgenerate

  assign hi   = {1'b0, a & ~mask} + {1'b0, b & ~mask} + ((ACC_W+1)'(cin) << APPROX_LSB);
  assign sum  = hi[ACC_W-1:0] | ((a | b) & mask);
  assign cout = hi[ACC_W];

endmodule

// File: rtl/approx_accum_stream.sv
// Streaming accumulator over len samples using the approximate LSB adder.
// Latency: in_ready 1 cycle after start, out_valid 1 cycle after last transfer; result held until out_ready.
module approx_accum_stream
  import approx_accum_stream_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 12,
  parameter int APPROX_LSB = 4,
  parameter int LEN_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              mode_exact,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              ovf,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   sum;
  logic [LEN_W-1:0]   count_q;
  logic [LEN_W-1:0]   len_q;
  logic               mode_q;
  logic               ovf_q;
  logic               cout;
  logic               xfer;
  logic               last;

  approx_lsb_adder #(
    .ACC_W      (ACC_W),
    .APPROX_LSB (APPROX_LSB)
  ) u_adder (
    .a     (acc_q),
    .b     (ACC_W'(in_data)),
    .exact (mode_q),
    .sum   (sum),
    .cout  (cout)
  );

  assign xfer = in_valid & in_ready;
  assign last = (count_q == len_q - LEN_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_ACCUM;
      ST_ACCUM: if (xfer && last) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q   <= len;
            mode_q  <= mode_exact;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (xfer) begin
            acc_q   <= sum;
            count_q <= count_q + LEN_W'(1);
            ovf_q   <= ovf_q | cout;
          end
        end
        default: ;
      endcase
    end
  end

  // Result bus is driven only while the result is being offered.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = out_valid ? acc_q : '0;
  assign ovf       = ovf_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_approx_accum_stream.sv
// Scoreboard bench for approx_accum_stream: expected results queued per job, compared on output.
module tb_approx_accum_stream;

  localparam int DATA_W     = 8;
  localparam int ACC_W      = 12;
  localparam int APPROX_LSB = 4;
  localparam int LEN_W      = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              mode_exact;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              ovf;
  logic              busy;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic             ovf;
  } exp_t;

  exp_t              sb_q[$];
  logic [DATA_W-1:0] smp [0:63];
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  approx_accum_stream #(
    .DATA_W     (DATA_W),
    .ACC_W      (ACC_W),
    .APPROX_LSB (APPROX_LSB),
    .LEN_W      (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .mode_exact (mode_exact),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .ovf        (ovf),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic, low K bits ORed, carry from bit K-1 pair.
  function automatic exp_t model(input int n, input bit exact);
    exp_t r;
    int   acc = 0;
    int   s, b, lo, hi, cin;
    bit   c = 0;
    for (int i = 0; i < n; i++) begin
      b = int'(smp[i]);
      if (exact) begin
        s = acc + b;
      end else begin
        lo  = (acc | b) % (1 << APPROX_LSB);
        cin = ((acc >> (APPROX_LSB - 1)) & 1) & ((b >> (APPROX_LSB - 1)) & 1);
        hi  = (acc >> APPROX_LSB) + (b >> APPROX_LSB) + cin;
        s   = (hi << APPROX_LSB) + lo;
      end
      if (s >= (1 << ACC_W)) c = 1;
      acc = s % (1 << ACC_W);
    end
    r.data = acc[ACC_W-1:0];
    r.ovf  = c;
    return r;
  endfunction

  task automatic collect(input int hold);
    exp_t e;
    int   w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("out_valid_wait", out_valid, 1);
    check("sb_size", sb_q.size(), 1);
    e = sb_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      start = (h == 2);
      len   = 8'd3;
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, e.data);
    end
    start = 1'b0;
    check("out_data", out_data, e.data);
    check("ovf", ovf, e.ovf);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_valid", out_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  // Starts on the current negedge so jobs run back-to-back after a handshake.
  task automatic run_job(input int n, input bit exact, input int drop_pct, input int hold);
    int idx = 0;
    int budget = 0;
    bit rdy;
    sb_q.push_back(model(n, exact));
    start      = 1'b1;
    len        = LEN_W'(n);
    mode_exact = exact;
    @(negedge clk);
    start = 1'b0;
    check("start_in_ready", in_ready, (n != 0));
    check("start_busy", busy, 1);
    while (idx < n && budget < 2000) begin
      rdy      = in_ready;
      in_valid = ($urandom_range(99) >= drop_pct);
      in_data  = smp[idx];
      @(negedge clk);
      if (in_valid && rdy) idx++;
      budget++;
    end
    in_valid = 1'b0;
    if (idx < n) check("feed_timeout", idx, n);
    check("out_valid_lat", out_valid, 1);
    if (n == 0) check("len0_no_ready", in_ready, 0);
    collect(hold);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; mode_exact = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    smp[0] = 8'd10; smp[1] = 8'd20; smp[2] = 8'd30;
    run_job(3, 1'b1, 0, 0);
    check("t1_value", out_data, 0);

    smp[0] = 8'h0F; smp[1] = 8'h01;
    run_job(2, 1'b0, 0, 0);
    smp[0] = 8'h08; smp[1] = 8'h08;
    run_job(2, 1'b0, 0, 0);
    run_job(2, 1'b1, 0, 0);

    for (int i = 0; i < 17; i++) smp[i] = 8'hFF;
    run_job(17, 1'b1, 0, 0);

    smp[0] = 8'h33; smp[1] = 8'h44; smp[2] = 8'h0C;
    run_job(3, 1'b0, 0, 5);

    run_job(0, 1'b1, 0, 0);

    // Abort a job mid-stream with reset.
    for (int i = 0; i < 4; i++) smp[i] = 8'hC8;
    start = 1'b1; len = 8'd4; mode_exact = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = smp[0];
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_busy", busy, 0);
    rst = 1'b0;
    smp[0] = 8'd5;
    run_job(1, 1'b1, 0, 0);

    for (int j = 0; j < 12; j++) begin
      int n;
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) smp[i] = DATA_W'($urandom_range(255));
      run_job(n, 1'($urandom_range(1)), 30, (j % 4 == 0) ? 2 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
